student_iis_receiver: RTL and testbench

I2S (Philips) serial-to-parallel receiver for the codec ADC path. It deserialises AC_ADC_SDATA into signed left and right samples. It uses the LRCLK/BCLK edge strobes produced by the shared IIS clock generator, so it mirrors the DAC-side transmitter. Once per stereo frame it presents a registered L/R pair with a single-cycle valid strobe to the FIR filter input.

---
 rtl/student_iis_receiver_if.sv | 24 ++
 rtl/student_iis_receiver.sv | 118 +++++++++++
 tb/tb_student_iis_receiver.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/student_iis_receiver_if.sv
// Output bundle of the I2S ADC receiver toward the FIR input.
// master: receiver drives samples/strobes; slave: FIR side reads them.
interface student_iis_receiver_if #(
  parameter int DATA_SIZE_FIR_IN = 16
) ();
  logic signed [DATA_SIZE_FIR_IN-1:0] Data_O_L;
  logic signed [DATA_SIZE_FIR_IN-1:0] Data_O_R;
  logic                               valid_strobe_O;
  logic                               frame_err_O;

  modport master (
    output Data_O_L,
    output Data_O_R,
    output valid_strobe_O,
    output frame_err_O
  );

  modport slave (
    input Data_O_L,
    input Data_O_R,
    input valid_strobe_O,
    input frame_err_O
  );
endinterface

// File: rtl/student_iis_receiver.sv
// I2S (Philips) ADC receiver: deserialises SDATA into signed L/R samples.
// Ports: clk_i, rst_ni, LRCLK/BCLK edge strobes, AC_ADC_SDATA; fir = output bundle.
module student_iis_receiver #(
  parameter int DATA_SIZE_FIR_IN = 16,
  parameter int CODEC_WIDTH      = 24
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          LRCLK_Rise,
  input  logic                          LRCLK_Fall,
  input  logic                          BCLK_Rise,
  input  logic                          AC_ADC_SDATA,
  student_iis_receiver_if.master        fir
);

  localparam int CNT_W = $clog2(CODEC_WIDTH + 1);
  localparam int DW    = DATA_SIZE_FIR_IN;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    WAIT
  } state_t;

  state_t                 state;
  state_t                 state_d;
  logic [CODEC_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]       cnt;
  logic                   ch;
  logic                   lvalid;
  logic                   done;
  logic [DW-1:0]          hold;
  logic [DW-1:0]          data_l;
  logic [DW-1:0]          data_r;
  logic                   valid;
  logic                   ferr;
  logic [DW-1:0]          trunc;

  logic start;
  logic abort;
  logic shift_en;
  logic last;

  assign trunc = shreg[CODEC_WIDTH-1 -: DW];

  // Rise is only honoured once a left slot has been seen (not in IDLE).
  always_comb begin
    start    = LRCLK_Fall | (LRCLK_Rise & (state != IDLE));
    abort    = start & ((state == SKIP) | (state == SHIFT));
    shift_en = ~start & BCLK_Rise & (state == SHIFT);
    last     = shift_en & (cnt == CNT_W'(CODEC_WIDTH - 1));
    state_d  = state;
    if (start) begin
      state_d = SKIP;
    end else begin
      case (state)
        SKIP:    if (BCLK_Rise) state_d = SHIFT;
        SHIFT:   if (last) state_d = WAIT;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // done: slot finished last cycle; the full word is now in shreg.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg  <= '0;
      cnt    <= '0;
      ch     <= 1'b0;
      lvalid <= 1'b0;
      done   <= 1'b0;
      hold   <= '0;
      data_l <= '0;
      data_r <= '0;
      valid  <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      valid <= 1'b0;
      ferr  <= abort;
      done  <= last;
      if (done) begin
        if (!ch) begin
          hold   <= trunc;
          lvalid <= 1'b1;
        end else if (lvalid) begin
          data_l <= hold;
          data_r <= trunc;
          valid  <= 1'b1;
          lvalid <= 1'b0;
        end
      end
      if (start) begin
        ch    <= ~LRCLK_Fall;
        cnt   <= '0;
        shreg <= '0;
        if (abort) lvalid <= 1'b0;
      end else if (shift_en) begin
        shreg <= {shreg[CODEC_WIDTH-2:0], AC_ADC_SDATA};
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  assign fir.Data_O_L       = data_l;
  assign fir.Data_O_R       = data_r;
  assign fir.valid_strobe_O = valid;
  assign fir.frame_err_O    = ferr;

endmodule

// File: tb/tb_student_iis_receiver.sv
// Self-checking bench for student_iis_receiver.
// Table-driven frames plus hand sequences; scoreboard checks every strobe.
module tb_student_iis_receiver;
  localparam int DW = 16;
  localparam int CW = 24;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic lr_rise = 1'b0;
  logic lr_fall = 1'b0;
  logic bclk = 1'b0;
  logic sdata = 1'b0;

  always #5 clk = ~clk;

  student_iis_receiver_if #(.DATA_SIZE_FIR_IN(DW)) fir ();

  student_iis_receiver #(
    .DATA_SIZE_FIR_IN(DW),
    .CODEC_WIDTH(CW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .LRCLK_Rise(lr_rise),
    .LRCLK_Fall(lr_fall),
    .BCLK_Rise(bclk),
    .AC_ADC_SDATA(sdata),
    .fir(fir)
  );

  logic [DW-1:0] out_l;
  logic [DW-1:0] out_r;
  assign out_l = fir.Data_O_L;
  assign out_r = fir.Data_O_R;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } exp_t;

  typedef struct {
    logic [CW-1:0] l;
    logic [CW-1:0] r;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    bit            pre_rst;
    bit            pre_rise;
    bit            coinc;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int cyc_cnt = 0;
  int lsb_cyc = 0;
  logic [DW-1:0] pl;
  logic [DW-1:0] pr;
  bit pv;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (!rst_ni) begin
      pl = '0;
      pr = '0;
      pv = 1'b0;
    end else begin
      if (fir.frame_err_O) n_ferr++;
      if (fir.valid_strobe_O) begin
        n_valid++;
        chk("strobe_width", 32'(pv), 0);
        chk("latency", cyc_cnt - lsb_cyc, 2);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_left", 32'(out_l), 32'(mon_e.l));
          chk("sb_right", 32'(out_r), 32'(mon_e.r));
        end
      end else begin
        chk("hold_left", 32'(out_l), 32'(pl));
        chk("hold_right", 32'(out_r), 32'(pr));
      end
      pl = out_l;
      pr = out_r;
      pv = fir.valid_strobe_O;
    end
  end

  task automatic cyc(input bit lf, input bit lr, input bit bc, input bit sd);
    @(negedge clk);
    lr_fall = lf;
    lr_rise = lr;
    bclk    = bc;
    sdata   = sd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  // nb BCLKs after the edge: first is the delay bit, then data MSB first.
  task automatic send_slot(input bit left, input logic [CW-1:0] w,
                           input int nb, input bit coinc);
    bit d;
    cyc(left, !left, coinc, coinc ? ~w[CW-1] : 1'b0);
    idle(1);
    for (int i = 0; i < nb; i++) begin
      if (i >= 1 && i <= CW) d = w[CW-i];
      else d = 1'($urandom);
      cyc(0, 0, 1, d);
      if (!left && i == CW) lsb_cyc = cyc_cnt;
      idle(1);
    end
  endtask

  task automatic push_exp(input logic [CW-1:0] l, input logic [CW-1:0] r);
    exp_t e;
    e.l = l[CW-1 -: DW];
    e.r = r[CW-1 -: DW];
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [CW-1:0] l, input logic [CW-1:0] r,
                            input bit coinc);
    push_exp(l, r);
    send_slot(1, l, 32, coinc);
    send_slot(0, r, 32, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_ni  = 1'b0;
    lr_fall = 1'b0;
    lr_rise = 1'b0;
    bclk    = 1'b0;
    sdata   = 1'b0;
    #1;
    chk("rst_left", 32'(out_l), 0);
    chk("rst_right", 32'(out_r), 0);
    chk("rst_valid", 32'(fir.valid_strobe_O), 0);
    chk("rst_ferr", 32'(fir.frame_err_O), 0);
    repeat (3) @(negedge clk);
    #2;
    rst_ni = 1'b1;
  endtask

  vec_t tv[3];
  int nv0;
  int nf0;

  initial begin
    tv[0] = '{24'h123456, 24'hFEDCBA, 16'h1234, 16'hFEDC, 1'b1, 1'b0, 1'b0};
    tv[1] = '{24'h7FFFFF, 24'h800000, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0};
    tv[2] = '{24'hA5A5A5, 24'h5A5A5A, 16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 3; i++) begin
      if (tv[i].pre_rst) do_reset();
      nv0 = n_valid;
      nf0 = n_ferr;
      if (tv[i].pre_rise) begin
        send_slot(0, 24'h5555AA, 32, 0);
        idle(4);
        chk("rise_first_no_strobe", n_valid - nv0, 0);
      end
      send_frame(tv[i].l, tv[i].r, tv[i].coinc);
      idle(4);
      chk("vec_strobes", n_valid - nv0, 1);
      chk("vec_ferr", n_ferr - nf0, 0);
      chk("vec_left", 32'(out_l), 32'(tv[i].el));
      chk("vec_right", 32'(out_r), 32'(tv[i].er));
    end

    // Right slot cut short after 10 data bits.
    nv0 = n_valid;
    nf0 = n_ferr;
    send_slot(1, 24'h13579B, 32, 0);
    send_slot(0, 24'h2468AC, 11, 0);
    cyc(1, 0, 0, 0);
    idle(4);
    chk("short_ferr", n_ferr - nf0, 1);
    chk("short_no_strobe", n_valid - nv0, 0);
    chk("short_keep_left", 32'(out_l), 32'hA5A5);
    chk("short_keep_right", 32'(out_r), 32'h5A5A);

    // Reset in the middle of the left slot just started.
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 1'($urandom));
      idle(1);
    end
    do_reset();
    nv0 = n_valid;
    nf0 = n_ferr;
    push_exp(24'h000100, 24'hFFFF00);
    send_slot(1, 24'h000100, 32, 0);
    chk("post_rst_left_zero", 32'(out_l), 0);
    chk("post_rst_right_zero", 32'(out_r), 0);
    send_slot(0, 24'hFFFF00, 32, 0);
    idle(4);
    chk("post_rst_left", 32'(out_l), 32'h0001);
    chk("post_rst_right", 32'(out_r), 32'hFFFF);
    chk("post_rst_strobes", n_valid - nv0, 1);
    chk("post_rst_ferr", n_ferr - nf0, 0);

    // Back-to-back random frames.
    nv0 = n_valid;
    nf0 = n_ferr;
    for (int i = 0; i < 100; i++) begin
      send_frame(24'($urandom), 24'($urandom), 0);
    end
    idle(4);
    chk("rand_strobes", n_valid - nv0, 100);
    chk("rand_ferr", n_ferr - nf0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_bad, n_chk);
    $finish;
  end
endmodule
